// File: rtl/serial_bus_initiator.sv
// Parallel-command to serial-frame initiator: sends the address and write data LSB-first,
// collects serial read data, and reports completion with a one-cycle response pulse.
//
// state     | meaning
// IDLE      | ready for a command
// REQ       | frame requested, waiting for slave_ready
// SEND_ADDR | address bits on wr_bus, LSB first
// SEND_DATA | write data bits on wr_bus, LSB first
// WAIT_RD   | waiting for the first read bit (slave_valid)
// RECV      | collecting read bits 1..DATA_WIDTH-1
// DONE      | one-cycle response pulse
module serial_bus_initiator #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_mode,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mode,
    output logic                  wr_bus,
    output logic                  master_valid,
    input  logic                  slave_ready,
    input  logic                  rd_bus,
    input  logic                  slave_valid,
    output logic                  master_ready
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BW   = $clog2(MAXW) + 1;
    localparam int WW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_WIDTH - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] RECV_LAST = BW'((DATA_WIDTH > 1) ? DATA_WIDTH - 2 : 0);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, REQ, SEND_ADDR, SEND_DATA, WAIT_RD, RECV, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [WW-1:0]         wait_q, wait_d, wait_inc;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_shift;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  wr_bus_q, wr_bus_d;
    logic                  mv_q, mv_d;
    logic                  mr_q, mr_d;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        wait_d    = wait_q;
        mode_d    = mode_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wait_inc  = wait_q + WW'(1);
        // read bits arrive LSB first, so each new bit enters at the top
        rx_shift  = (rx_q >> 1) | (DATA_WIDTH'(rd_bus) << (DATA_WIDTH - 1));

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = REQ;
                    mode_d    = cmd_mode;
                    addr_sh_d = cmd_addr;
                    data_sh_d = cmd_wdata;
                    rx_d      = '0;
                end
            end
            REQ: begin
                if (slave_ready) begin
                    state_d = SEND_ADDR;
                end else if (wait_inc >= WAIT_MAX) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            SEND_ADDR: begin
                addr_sh_d = addr_sh_q >> 1;
                if (bit_q == ADDR_LAST) begin
                    state_d = mode_q ? SEND_DATA : WAIT_RD;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            SEND_DATA: begin
                data_sh_d = data_sh_q >> 1;
                if (bit_q == DATA_LAST) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            WAIT_RD: begin
                if (slave_valid) begin
                    rx_d = rx_shift;
                    if (DATA_WIDTH > 1) begin
                        state_d = RECV;
                    end else begin
                        state_d = DONE;
                        rdata_d = rx_shift;
                        err_d   = 1'b0;
                    end
                end else if (wait_inc >= WAIT_MAX) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            RECV: begin
                if (!slave_valid) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    rx_d = rx_shift;
                    if (bit_q == RECV_LAST) begin
                        state_d = DONE;
                        rdata_d = rx_shift;
                        err_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            bit_d  = '0;
            wait_d = '0;
        end

        // outputs are registered from the next state so they line up with it
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        mv_d        = (state_d == REQ) || (state_d == SEND_ADDR) || (state_d == SEND_DATA);
        mr_d        = (state_d == WAIT_RD) || (state_d == RECV);
        if (state_d == SEND_ADDR) begin
            wr_bus_d = addr_sh_d[0];
        end else if (state_d == SEND_DATA) begin
            wr_bus_d = data_sh_d[0];
        end else begin
            wr_bus_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            wait_q      <= '0;
            mode_q      <= 1'b0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            wr_bus_q    <= 1'b0;
            mv_q        <= 1'b0;
            mr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            wait_q      <= wait_d;
            mode_q      <= mode_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            wr_bus_q    <= wr_bus_d;
            mv_q        <= mv_d;
            mr_q        <= mr_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign mode         = mode_q;
    assign wr_bus       = wr_bus_q;
    assign master_valid = mv_q;
    assign master_ready = mr_q;

endmodule

// File: tb/tb_serial_bus_initiator.sv
// Bench for serial_bus_initiator: table of directed transactions checked cycle by cycle
// against a hand-built timeline, plus reset-abort and back-to-back sequences.
module tb_serial_bus_initiator;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        mode;
    logic        wr_bus;
    logic        master_valid;
    logic        slave_ready;
    logic        rd_bus;
    logic        slave_valid;
    logic        master_ready;

    int errors = 0;
    int checks = 0;

    serial_bus_initiator dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rd_bus       (rd_bus),
        .slave_valid  (slave_valid),
        .master_ready (master_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // sr: cycles with slave_ready=0 after accept; sv: idle WAIT_RD cycles before read bits;
    // drop: number of read bits before slave_valid falls (0 = full word); lat: rsp_valid cycle
    typedef struct {
        logic        md;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdat;
        int          sr;
        int          sv;
        int          drop;
        logic        noise;
        int          lat;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   w0, s, nb;
        logic inreq, inaddr, indata, inrd, e_wb;
        logic [5:0] exp_o;
        w0 = v.sr + 18;
        s  = w0 + v.sv;
        nb = (v.drop > 0) ? v.drop : 8;
        cmd_valid   = 1'b1;
        cmd_mode    = v.md;
        cmd_addr    = v.addr;
        cmd_wdata   = v.wdata;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_mode  = ~v.md;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        for (int c = 1; c <= v.lat + 1; c++) begin
            @(negedge clk);
            inreq  = (c <= v.sr + 1) && (c < v.lat);
            inaddr = !inreq && (c >= v.sr + 2) && (c < v.sr + 18) && (c < v.lat);
            indata = v.md && (c >= v.sr + 18) && (c < v.lat);
            inrd   = !v.md && (c >= v.sr + 18) && (c < v.lat);
            e_wb   = inaddr ? v.addr[c - v.sr - 2] : (indata ? v.wdata[c - v.sr - 18] : 1'b0);
            exp_o  = {(c == v.lat + 1), inreq | inaddr | indata, inrd, (c == v.lat), e_wb, v.md};
            check($sformatf("v%0d c%0d {cmd_ready,master_valid,master_ready,rsp_valid,wr_bus,mode}", idx, c),
                  32'({cmd_ready, master_valid, master_ready, rsp_valid, wr_bus, mode}), 32'(exp_o));
            if (c == v.lat || c == v.lat + 1) begin
                check($sformatf("v%0d c%0d rsp_rdata", idx, c), 32'(rsp_rdata), 32'(v.exp_rdata));
                check($sformatf("v%0d c%0d rsp_err", idx, c), 32'(rsp_err), 32'(v.exp_err));
            end
            slave_ready = (c > v.sr);
            if (!v.md && c >= s && c < s + nb) begin
                slave_valid = 1'b1;
                rd_bus      = v.rdat[c - s];
            end else if (v.noise && (v.md || c < w0)) begin
                slave_valid = 1'b1;
                rd_bus      = 1'b1;
            end else begin
                slave_valid = 1'b0;
                rd_bus      = 1'b0;
            end
        end
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
    endtask

    initial begin
        vec_t v_after;
        int   np, p1, p2;

        //            md    addr      wdata  rdat   sr   sv   drop noise lat  rdata  err
        vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00,   0,   0, 0, 1'b0,  26, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 16'h0003, 8'h00, 8'h3C,   0,   5, 0, 1'b0,  31, 8'h3C, 1'b0};
        vecs[2] = '{1'b0, 16'hFFFF, 8'h00, 8'h81,   3,   0, 0, 1'b1,  29, 8'h81, 1'b0};
        vecs[3] = '{1'b1, 16'h8001, 8'h5A, 8'h00,   2,   0, 0, 1'b1,  28, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 16'hBEEF, 8'h77, 8'h00, 999,   0, 0, 1'b0, 256, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 16'h0F0F, 8'hC3, 8'h00, 254,   0, 0, 1'b0, 280, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 16'h0010, 8'h00, 8'hFF,   0,   2, 3, 1'b0,  24, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 16'h4321, 8'h00, 8'hAA,   0, 999, 0, 1'b0, 273, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 16'h00C0, 8'h00, 8'h96,   0, 254, 0, 1'b0, 280, 8'h96, 1'b0};
        v_after = '{1'b1, 16'h0001, 8'h7E, 8'h00,   0,   0, 0, 1'b0,  26, 8'h00, 1'b0};

        rstn        = 1'b0;
        cmd_valid   = 1'b0;
        cmd_mode    = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({cmd_ready, rsp_valid, rsp_err, mode, wr_bus, master_valid, master_ready}),
              32'(7'b1000000));
        check("reset rsp_rdata", 32'(rsp_rdata), 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // reset while bit 7 of the address is on the wire
        cmd_valid   = 1'b1;
        cmd_mode    = 1'b1;
        cmd_addr    = 16'h0080;
        cmd_wdata   = 8'h11;
        slave_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-frame bit7 {master_valid,wr_bus}", 32'({master_valid, wr_bus}), 32'(2'b11));
        #2;
        rstn = 1'b0;
        #1;
        check("abort outputs in reset", 32'({cmd_ready, rsp_valid, rsp_err, mode, wr_bus, master_valid, master_ready}),
              32'(7'b1000000));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort hold %0d", k),
                  32'({cmd_ready, rsp_valid, master_valid, master_ready, rsp_rdata}), 32'({4'b1000, 8'h00}));
        end
        rstn        = 1'b1;
        slave_ready = 1'b0;
        run_vec(v_after, 9);

        // back-to-back with cmd_valid held high
        cmd_valid   = 1'b1;
        cmd_mode    = 1'b1;
        cmd_addr    = 16'h00F0;
        cmd_wdata   = 8'h3C;
        slave_ready = 1'b1;
        np = 0;
        p1 = -1;
        p2 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                np++;
                if (np == 1) p1 = c;
                else if (np == 2) p2 = c;
            end
            if (c == 6)  check("b2b first cmd addr bit4", 32'(wr_bus), 32'h1);
            if (c == 27) check("b2b cmd_ready after DONE", 32'(cmd_ready), 32'h1);
            if (c == 28) check("b2b cmd_ready busy", 32'(cmd_ready), 32'h0);
            if (c == 37) check("b2b second cmd addr bit8", 32'(wr_bus), 32'h1);
            if (c == 26) begin
                cmd_addr  = 16'h0F00;
                cmd_wdata = 8'hC3;
            end
            if (c == 28) cmd_valid = 1'b0;
        end
        check("b2b pulse count", 32'(np), 32'd2);
        check("b2b first pulse cycle", 32'(p1), 32'd26);
        check("b2b second pulse cycle", 32'(p2), 32'd53);
        check("b2b final err", 32'(rsp_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_bus_initiator.md
SERIAL_BUS_INITIATOR -- requirements
Module: serial_bus_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: number of address bits serialized per frame.
REQ-002 Parameter DATA_WIDTH, default 8: number of data bits per write or read.
REQ-003 Parameter TIMEOUT, default 255: maximum number of wait cycles in REQ or WAIT_RD before an error response.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  parallel command present.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_mode  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
REQ-013 rsp_err  out  1  timeout or protocol error; valid with rsp_valid.
REQ-014 mode  out  1  registered copy of cmd_mode, toward the slave.
REQ-015 wr_bus  out  1  serial address/data toward the slave.
REQ-016 master_valid  out  1  initiator is driving a frame.
REQ-017 slave_ready  in  1  slave can accept a frame.
REQ-018 rd_bus  in  1  serial read data from the slave.
REQ-019 slave_valid  in  1  slave is driving read data.
REQ-020 master_ready  out  1  initiator can take read data.

Function
REQ-021 The block SHALL be a state machine with states IDLE, REQ, SEND_ADDR, SEND_DATA, WAIT_RD, RECV, DONE.
- REQ-022 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0.
- REQ-023 On cmd_valid&cmd_ready, the block SHALL capture mode, addr, and wdata, then enter REQ.
- REQ-024 In REQ, master_valid SHALL be 1 and wr_bus SHALL be 0.
  - When slave_ready is sampled as 1, the block SHALL enter SEND_ADDR.
- REQ-025 In SEND_ADDR, wr_bus SHALL carry addr LSB-first, one bit per cycle for ADDR_WIDTH cycles, with master_valid=1.
  - After the last bit, a write SHALL enter SEND_DATA and a read SHALL enter WAIT_RD.
- REQ-026 In SEND_DATA, wr_bus SHALL carry wdata LSB-first for DATA_WIDTH cycles, with master_valid=1, and then enter DONE.
- REQ-027 In WAIT_RD and RECV, master_valid SHALL be 0 and master_ready SHALL be 1; elsewhere master_ready SHALL be 0.
- REQ-028 In WAIT_RD, the first cycle with slave_valid=1 SHALL sample rd_bus as bit 0.
  - If DATA_WIDTH>1, the block SHALL enter RECV; otherwise it SHALL enter DONE.
- REQ-029 In RECV, the block SHALL sample bits 1..DATA_WIDTH-1 on consecutive cycles, then enter DONE.
  - If slave_valid=0 in any RECV cycle, the block SHALL enter DONE with rsp_err=1 and rsp_rdata=0.
- REQ-030 In DONE, rsp_valid SHALL be 1 for exactly one cycle, and the block SHALL then return to IDLE.
  - rsp_rdata and rsp_err SHALL hold their values until the next DONE.
- REQ-031 A wait counter SHALL clear on entry to REQ and to WAIT_RD and increment each cycle without the awaited event.
  - When the counter reaches TIMEOUT, the block SHALL enter DONE with rsp_err=1 and rsp_rdata=0.
- REQ-032 An event arriving in the same cycle the counter reaches TIMEOUT SHALL win, and no error SHALL be flagged.
- REQ-033 Latency: with slave_ready=1 on entry to REQ, a write SHALL pulse rsp_valid ADDR_WIDTH+DATA_WIDTH+2 cycles after the accept cycle.
  - For a read, the same latency SHALL apply when slave_valid=1 in the first WAIT_RD cycle.
- REQ-034 The bit counter SHALL be $clog2(max(ADDR_WIDTH,DATA_WIDTH))+1 bits wide and SHALL clear on every state entry.
- REQ-035 The mode output SHALL remain stable from REQ through DONE.
- REQ-036 Changes on cmd_* outside the accept cycle SHALL have no effect.
- REQ-037 slave_valid in states other than WAIT_RD and RECV SHALL be ignored.
- REQ-038 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational input-to-output path.

Reset
REQ-039 While rstn=0, the block SHALL hold state IDLE, and every output SHALL be 0 except cmd_ready.
  - cmd_ready SHALL be 1 in reset.
  - All counters and captured registers SHALL be cleared.
REQ-040 Reset asserted mid-frame SHALL immediately drop master_valid and master_ready, and no rsp_valid SHALL be produced for the aborted command.

Verification
REQ-041 Write: addr=0x1234, wdata=0xA5, slave_ready tied 1 -> wr_bus bits 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 then 1,0,1,0,0,1,0,1; rsp_valid at accept+26; rsp_err=0.
REQ-042 Read: addr=0x0003, slave drives 0x3C LSB-first with slave_valid high for 8 cycles starting 5 cycles into WAIT_RD -> rsp_rdata=0x3C; rsp_err=0; rsp_valid at accept+31.
REQ-043 Timeout: slave_ready held 0, TIMEOUT=255 -> rsp_valid with rsp_err=1 and rsp_rdata=0; master_valid low afterwards; cmd_ready=1 the next cycle.
REQ-044 Protocol error: slave_valid drops after 3 read bits -> rsp_err=1; rsp_rdata=0.
REQ-045 Reset mid-address (bit 7) -> outputs zero and cmd_ready=1 within reset; a following write to 0x0001 completes normally.
REQ-046 Back-to-back commands: cmd_valid held high across two commands -> second accepted the cycle after DONE; no lost or duplicated rsp_valid.
